// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Sequencer for a downstream 4:1 single-bit multiplexer. Steps the mux
//   select through the enabled channels, holds each select for DWELL cycles,
//   captures the mux output into a per-channel sample register and flags
//   each capture with a one-cycle valid pulse. Supports single-sweep and
//   continuous scanning with immediate abort.
//
// Parameters
//   DWELL     settle cycles the select is held before sampling (1..255)
//   CNT_W     dwell counter width, must hold DWELL-1
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     request to begin a sweep (only honoured when idle)
//   stop_i      abort, back to idle on the next edge (wins over start_i)
//   mode_i      0 = single sweep, 1 = continuous
//   mask_i      channel enables, latched at start and at each wrap
//   o_in_i      output of the downstream mux
//   s_o         mux select
//   samples_o   last captured value per channel
//   ch_id_o     channel of the current valid pulse
//   valid_o     one-cycle pulse, samples_o[ch_id_o] just updated
//   busy_o      high whenever a sweep is in progress
//   done_o      one-cycle pulse at the end of a single sweep
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       mode_i,
  input  logic [3:0] mask_i,
  input  logic       o_in_i,
  output logic [1:0] s_o,
  output logic [3:0] samples_o,
  output logic [1:0] ch_id_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       samples_q, samples_d;
  logic [1:0]       ch_id_q, ch_id_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Lowest enabled channel of the live mask input (used at start and wrap).
  logic [1:0] low_idx;
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) low_idx = 2'(i);
    end
  end

  // Next latched-enabled channel strictly above the current select; no wrap,
  // running off the top means the sweep is complete.
  logic       nxt_found;
  logic [1:0] nxt_idx;
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(s_q)) && mask_q[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    s_d       = s_q;
    samples_d = samples_q;
    ch_id_d   = ch_id_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    if (stop_i) begin
      // Abort: select and samples hold, any pending capture is dropped.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && (mask_i != 4'd0)) begin
            mask_d  = mask_i;
            s_d     = low_idx;
            cnt_d   = DWELL_M1;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_SAMPLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_SAMPLE: begin
          samples_d[s_q] = o_in_i;
          ch_id_d        = s_q;
          valid_d        = 1'b1;
          state_d        = ST_NEXT;
        end
        ST_NEXT: begin
          if (nxt_found) begin
            s_d     = nxt_idx;
            cnt_d   = DWELL_M1;
            state_d = ST_SETTLE;
          end else if (!mode_i) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Continuous wrap: pick up whatever mask is presented now.
            mask_d = mask_i;
            if (mask_i != 4'd0) begin
              s_d     = low_idx;
              cnt_d   = DWELL_M1;
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mask_q    <= 4'd0;
      s_q       <= 2'd0;
      samples_q <= 4'd0;
      ch_id_q   <= 2'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      s_q       <= s_d;
      samples_q <= samples_d;
      ch_id_q   <= ch_id_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_o       = s_q;
  assign samples_o = samples_q;
  assign ch_id_o   = ch_id_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: behavioural timeline model compared every
// cycle, plus literal timing/sample expectations for each directed scenario.
module tb_mux_scan_ctrl;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] mask = 4'd0;
  logic [3:0] mux_in = 4'd0;
  logic       o_in;
  logic [1:0] s, ch_id;
  logic [3:0] samples;
  logic       valid, busy, done;

  assign o_in = mux_in[s];

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .mode_i(mode), .mask_i(mask), .o_in_i(o_in), .s_o(s),
    .samples_o(samples), .ch_id_o(ch_id), .valid_o(valid),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, c0 = 0;
  int vcyc[$], vch[$], dcyc[$];
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - c0 + 1);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_s, m_ch;
  logic [3:0] m_samples, m_mask;
  logic       m_valid, m_busy, m_done, m_abort;

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int above(input logic [3:0] m, input int c);
    for (int i = c + 1; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  // One clock edge of an active sweep; flags abort on stop or reset.
  task automatic m_step();
    @(posedge clk or negedge rst_n);
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (!rst_n) m_abort = 1'b1;
    else if (stop) begin
      m_abort = 1'b1;
      m_busy  = 1'b0;
    end
  endtask

  task automatic m_sweep();
    int ch;
    m_abort = 1'b0;
    m_mask  = mask;
    ch      = lowest(m_mask);
    m_s     = 2'(ch);
    m_busy  = 1'b1;
    forever begin
      // DWELL settle cycles, then the sampling cycle ends with the capture edge
      for (int k = 0; k < DWELL + 1; k++) begin
        m_step();
        if (m_abort) return;
      end
      m_samples[ch] = mux_in[ch];
      m_ch    = 2'(ch);
      m_valid = 1'b1;
      m_step();
      if (m_abort) return;
      if (above(m_mask, ch) >= 0) begin
        ch  = above(m_mask, ch);
        m_s = 2'(ch);
      end else if (!mode) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        return;
      end else begin
        m_mask = mask;
        if (m_mask == 4'd0) begin
          m_busy = 1'b0;
          return;
        end
        ch  = lowest(m_mask);
        m_s = 2'(ch);
      end
    end
  endtask

  initial begin
    forever begin
      if (!rst_n) begin
        m_s = 0; m_ch = 0; m_samples = 0; m_mask = 0;
        m_valid = 0; m_busy = 0; m_done = 0;
        @(posedge rst_n);
      end
      @(posedge clk or negedge rst_n);
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (rst_n && start && !stop && (mask != 4'd0)) m_sweep();
    end
  end

  // ---------------- cycle counter, recorder, compare ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (valid) begin
        vcyc.push_back(cyc - c0 + 1);
        vch.push_back(int'(ch_id));
      end
      if (done) dcyc.push_back(cyc - c0 + 1);
      if (busy) busy_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    check("outputs{s,samples,ch,valid,busy,done}",
          {21'd0, s, samples, ch_id, valid, busy, done},
          {21'd0, m_s, m_samples, m_ch, m_valid, m_busy, m_done});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    vcyc.delete(); vch.delete(); dcyc.delete();
    busy_cnt = 0;
  endtask

  task automatic do_start(input logic [3:0] m);
    clear_log();
    mask  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_samples", {28'd0, samples}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single full sweep
    mux_in = 4'b1101; mode = 1'b0;
    do_start(4'b1111);
    repeat (30) tick();
    check("full_nvalid", vcyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("full_vcyc", vcyc[i], 6 + 6 * i);
      check("full_vch", vch[i], i);
    end
    check("full_ndone", dcyc.size(), 1);
    check("full_done_cyc", dcyc[0], 25);
    check("full_busy_cnt", busy_cnt, 24);
    check("full_samples", {28'd0, samples}, 32'h0000000d);

    // START pulsed while busy is ignored
    mux_in = 4'b0110;
    do_start(4'b1111);
    repeat (7) tick();
    mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (22) tick();
    check("busystart_nvalid", vcyc.size(), 4);
    check("busystart_last", vcyc[3], 24);
    check("busystart_done", dcyc[0], 25);
    check("busystart_samples", {28'd0, samples}, 32'h00000006);

    // Sparse mask
    mux_in = 4'b1001;
    do_start(4'b1010);
    repeat (16) tick();
    check("sparse_nvalid", vcyc.size(), 2);
    check("sparse_ch0", vch[0], 1);
    check("sparse_ch1", vch[1], 3);
    check("sparse_vcyc1", vcyc[1], 12);
    check("sparse_done", dcyc[0], 13);
    check("sparse_samples", {28'd0, samples}, 32'h0000000c);

    // Continuous, mask changed mid-dwell, then STOP on a capture edge
    mux_in = 4'b0111; mode = 1'b1;
    do_start(4'b0001);
    tick();
    mask = 4'b0110;
    repeat (23) tick();
    mux_in = 4'b0000;
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", {31'd0, valid}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_s_hold", {30'd0, s}, 32'd2);
    check("stop_samples", {28'd0, samples}, 32'h0000000f);
    mode = 1'b0;
    repeat (3) tick();
    check("cont_nvalid", vcyc.size(), 4);
    check("cont_ch", {vch[0][7:0], vch[1][7:0], vch[2][7:0], vch[3][7:0]}, 32'h00010201);
    check("cont_vcyc3", vcyc[3], 24);
    check("cont_ndone", dcyc.size(), 0);

    // START with empty mask
    do_start(4'b0000);
    repeat (10) tick();
    check("mask0_busy", busy_cnt, 0);
    check("mask0_ndone", dcyc.size(), 0);

    // START and STOP together from idle
    clear_log();
    mask = 4'b1111; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (10) tick();
    check("startstop_busy", busy_cnt, 0);
    check("startstop_nvalid", vcyc.size(), 0);

    // Reset mid-SETTLE
    do_start(4'b0100);
    repeat (2) tick();
    check("presreset_s", {30'd0, s}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("areset_outputs", {21'd0, s, samples, ch_id, valid, busy, done}, 32'd0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    clear_log();
    repeat (15) tick();
    check("postreset_busy", busy_cnt, 0);
    check("postreset_nvalid", vcyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the team's 4:1 single-bit multiplexer.
- Drives the mux select S[1:0] through the enabled channels and holds each select for a programmable settle time.
- Captures the mux output O_IN into per-channel sample registers and reports each capture with a one-cycle VALID pulse.
- Supports single-sweep and continuous scanning, with immediate abort.

Parameters:
- DWELL, 4, settle cycles S is held before sampling; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- STOP  input  1  abort; returns the block to IDLE on the next edge.
- MODE  input  1  0 = single sweep, 1 = continuous.
- MASK  input  4  channel enable, bit n = channel n; latched at START and at each continuous-mode wrap.
- O_IN  input  1  output of the downstream 4:1 mux.
- S  output  2  select to the mux.
- SAMPLES  output  4  last captured value per channel; bit n = channel n.
- CH_ID  output  2  channel of the current VALID.
- VALID  output  1  one-cycle pulse; SAMPLES[CH_ID] has just been updated.
- BUSY  output  1  high whenever the state is not IDLE.
- DONE  output  1  one-cycle pulse at the end of a single sweep.

Behaviour:
- Reset values (async, RST_N=0): state IDLE; S=0, SAMPLES=0, CH_ID=0, VALID=0, BUSY=0, DONE=0; dwell counter=0; latched mask=0. All outputs are registered.
- States and transitions:
  - IDLE:
    - START=1 and MASK!=0 -> latch MASK, set S to the lowest enabled channel, load counter with DWELL-1, go to SETTLE.
    - START with MASK=0 is ignored: no BUSY, no DONE.
  - SETTLE: counter decrements each cycle; at counter==0 go to SAMPLE. S is held stable for exactly DWELL cycles.
  - SAMPLE (1 cycle): on the exiting edge, SAMPLES[S]<=O_IN, CH_ID<=S, VALID<=1. Go to NEXT.
  - NEXT (1 cycle; VALID is high during it): search upward from S+1 for the next latched-enabled channel.
    - Channel found -> S<=that channel, reload counter, go to SETTLE.
    - No channel found (sweep complete), MODE=0 -> DONE<=1, go to IDLE.
    - No channel found, MODE=1 -> re-latch MASK.
      - New MASK!=0 -> S<=lowest enabled channel, go to SETTLE.
      - New MASK=0 -> go to IDLE without asserting DONE.
- Timing: START sampled at edge 0.
  - BUSY=1 and S valid from cycle 1.
  - First VALID in cycle DWELL+2.
  - Each channel costs DWELL+2 cycles.
  - DONE and BUSY=0 occur together, in the cycle after the last VALID.
- MODE is sampled only in NEXT at sweep completion. MASK changes mid-sweep have no effect until the next latch point.
- START while BUSY is ignored. START and STOP in the same cycle: STOP wins; the block stays in or returns to IDLE.
- STOP in any state -> IDLE on the next edge.
  - A capture that was due on that edge is suppressed: no VALID, no DONE.
  - S and SAMPLES hold their last values.
- VALID and DONE are never high for more than one consecutive cycle.
- Reset asserted mid-sweep clears everything immediately. After RST_N deasserts, the block stays in IDLE until a new START.
- Counter arithmetic is unsigned. With DWELL=1, SETTLE lasts one cycle.

Test Plan:
- Reset: RST_N=0 mid-SETTLE -> S, SAMPLES, VALID, BUSY and DONE are all 0 asynchronously; no activity after release until START.
- Single sweep, DWELL=4, MASK=4'b1111, mux inputs A..D = 1,0,1,1 -> S steps 0,1,2,3; VALID in cycles 6, 12, 18, 24 with CH_ID 0,1,2,3; SAMPLES=4'b1101; DONE in cycle 25 with BUSY=0.
- Sparse mask, MASK=4'b1010 -> only channels 1 and 3 visited; exactly 2 VALID pulses; SAMPLES bits 0 and 2 unchanged; DONE after the second VALID.
- Continuous, MODE=1, MASK=4'b0001; MASK changed to 4'b0110 mid-dwell -> change takes effect only at the wrap; next channel is 1; DONE never asserted.
- STOP asserted the cycle a capture is due -> no VALID, IDLE next cycle, SAMPLES unchanged.
- Corner cases:
  - START with MASK=0 -> no BUSY, no DONE.
  - START pulsed while BUSY -> ignored; the sweep completes unchanged.
  - START and STOP in the same cycle from IDLE -> block stays in IDLE.
